shared_reg_arbiter: RTL

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
// Round-robin arbiter in front of a small register file. Requesters present
// a packed {we, addr, wdata} command. The winner's command is latched and
// executed as one access. A done pulse carries the result. Grants rotate
// starting after the last requester that was served.
module shared_reg_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int AW   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*(1+AW+W)-1:0]   cmd,
  output logic [NREQ-1:0]            gnt,
  output logic [$clog2(NREQ)-1:0]    gnt_idx,
  output logic                       busy,
  output logic                       done,
  output logic [W-1:0]               rdata
);

  localparam int CW   = 1 + AW + W;
  localparam int IW   = $clog2(NREQ);
  localparam int NREG = 2 ** AW;

  // Code 3 is deliberately not a named state; the FSM treats it as illegal
  // and returns to IDLE without touching any datapath state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             ptr_q, ptr_d;
  logic [NREQ-1:0]           gnt_q, gnt_d;
  logic [IW-1:0]             gnt_idx_q, gnt_idx_d;
  logic                      done_q, done_d;
  logic [W-1:0]              rdata_q, rdata_d;
  logic [CW-1:0]             cmd_q, cmd_d;
  logic [NREG-1:0][W-1:0]    regfile_q;

  logic [NREQ-1:0][CW-1:0]   cmd_arr_s;
  logic [IW-1:0]             pick_s;
  logic                      wr_en_s;
  logic                      cmd_we_s;
  logic [AW-1:0]             cmd_addr_s;
  logic [W-1:0]              cmd_wdata_s;

  // Search upward from (p+1) mod NREQ with wrap-around. The loop runs from
  // the lowest priority to the highest, so the last hit is the winner.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   p);
    logic [IW-1:0] idx;
    int            c;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      c = (int'(p) + k) % NREQ;
      if (r[IW'(c)]) begin
        idx = IW'(c);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // The command bus is already laid out as NREQ packed slices.
  assign cmd_arr_s   = cmd;
  assign pick_s      = rr_pick(req, ptr_q);
  assign cmd_we_s    = cmd_q[CW-1];
  assign cmd_addr_s  = cmd_q[W +: AW];
  assign cmd_wdata_s = cmd_q[W-1:0];

  // State register; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: arbitrate in IDLE only, then run a fixed two-cycle access.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the output/datapath registers for each state.
  always_comb begin
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    ptr_d     = ptr_q;
    cmd_d     = cmd_q;
    wr_en_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
          gnt_idx_d = pick_s;
          cmd_d     = cmd_arr_s[pick_s];
        end else begin
          gnt_d     = '0;
        end
      end
      ACCESS: begin
        gnt_d  = '0;
        done_d = 1'b1;
        if (cmd_we_s) begin
          wr_en_s = 1'b1;
          rdata_d = cmd_wdata_s;
        end else begin
          rdata_d = regfile_q[cmd_addr_s];
        end
      end
      RESP: begin
        ptr_d = gnt_idx_q;
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  // Output and datapath registers. Reset wins, so an in-flight write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= IW'(NREQ - 1);
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      cmd_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      cmd_q     <= cmd_d;
    end
  end

  // Register file storage. The address width exactly covers all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      regfile_q <= '0;
    end else if (wr_en_s) begin
      regfile_q[cmd_addr_s] <= cmd_wdata_s;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rdata   = rdata_q;

endmodule
